// File: rtl/prio_arbiter.sv
// Four-requester arbiter with a registered one-hot grant, bounded hold time and forced-release pulse.
// Optional rotating priority is enabled by defining PRIO_ARBITER_RR_EN; default is fixed priority (3 highest).
module prio_arbiter #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enb,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       gnt_valid,
    output logic       preempt
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);

    state_t     state, state_next;
    logic [3:0] gnt_next;
    logic [1:0] id_next;
    logic       valid_next;
    logic       preempt_next;
    logic [7:0] hold_cnt, hold_next;
    logic [1:0] winner;

`ifdef PRIO_ARBITER_RR_EN
    logic [1:0] last_id, last_next;
    logic [1:0] idx;
    logic       found;

    // Search last_id-1, last_id-2, last_id-3, last_id; the first set request wins.
    always_comb begin
        winner = 2'd0;
        idx    = 2'd0;
        found  = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idx = last_id - 2'(k);
            if (!found && req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end
`else
    always_comb begin
        winner = 2'd0;
        for (int k = 0; k < 4; k++) begin
            if (req[k]) begin
                winner = 2'(k);
            end
        end
    end
`endif

    always_comb begin
        state_next   = state;
        gnt_next     = gnt;
        id_next      = gnt_id;
        valid_next   = gnt_valid;
        preempt_next = 1'b0;
        hold_next    = hold_cnt;
`ifdef PRIO_ARBITER_RR_EN
        last_next    = last_id;
`endif
        case (state)
            IDLE: begin
                gnt_next   = 4'b0000;
                valid_next = 1'b0;
                hold_next  = 8'd0;
                if (enb && (req != 4'b0000)) begin
                    gnt_next   = 4'b0001 << winner;
                    id_next    = winner;
                    valid_next = 1'b1;
                    hold_next  = 8'd1;
                    state_next = BUSY;
`ifdef PRIO_ARBITER_RR_EN
                    last_next  = winner;
`endif
                end
            end
            BUSY: begin
                // A normal release takes precedence over the hold limit, so no pulse then.
                if (!enb || !req[gnt_id]) begin
                    gnt_next   = 4'b0000;
                    valid_next = 1'b0;
                    hold_next  = 8'd0;
                    state_next = IDLE;
                end else if (hold_cnt == HOLD_LIMIT) begin
                    gnt_next     = 4'b0000;
                    valid_next   = 1'b0;
                    hold_next    = 8'd0;
                    preempt_next = 1'b1;
                    state_next   = IDLE;
                end else begin
                    hold_next = hold_cnt + 8'd1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            gnt       <= 4'b0000;
            gnt_id    <= 2'b00;
            gnt_valid <= 1'b0;
            preempt   <= 1'b0;
            hold_cnt  <= 8'd0;
`ifdef PRIO_ARBITER_RR_EN
            last_id   <= 2'd0;
`endif
        end else begin
            state     <= state_next;
            gnt       <= gnt_next;
            gnt_id    <= id_next;
            gnt_valid <= valid_next;
            preempt   <= preempt_next;
            hold_cnt  <= hold_next;
`ifdef PRIO_ARBITER_RR_EN
            last_id   <= last_next;
`endif
        end
    end

endmodule

// File: tb/tb_prio_arbiter.sv
// Table-driven self-checking bench for prio_arbiter (MAX_HOLD=4), covering fixed and rotating builds.
module tb_prio_arbiter;

    localparam int HOLD = 4;

    logic       clk;
    logic       rst;
    logic       enb;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_valid;
    logic       preempt;

    int checks;
    int failures;

    typedef struct {
        logic       rst;
        logic       enb;
        logic [3:0] req;
        logic [3:0] gnt;
        logic [1:0] id;
        logic       valid;
        logic       pre;
    } vec_t;

    vec_t vecs[$];

    prio_arbiter #(.MAX_HOLD(HOLD)) dut (
        .clk       (clk),
        .rst       (rst),
        .enb       (enb),
        .req       (req),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .preempt   (preempt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive inputs just after an edge, then sample 1 time unit after the next edge.
    task automatic apply_stimulus(input logic r, input logic e, input logic [3:0] q);
        rst = r;
        enb = e;
        req = q;
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input logic [3:0] eg, input logic [1:0] eid,
                                input logic ev, input logic ep);
        checks++;
        if (gnt !== eg) begin
            failures++;
            $display("[TB] FAIL %s gnt: got %b, expected %b", name, gnt, eg);
        end
        checks++;
        if (gnt_id !== eid) begin
            failures++;
            $display("[TB] FAIL %s gnt_id: got %0d, expected %0d", name, gnt_id, eid);
        end
        checks++;
        if (gnt_valid !== ev) begin
            failures++;
            $display("[TB] FAIL %s gnt_valid: got %b, expected %b", name, gnt_valid, ev);
        end
        checks++;
        if (preempt !== ep) begin
            failures++;
            $display("[TB] FAIL %s preempt: got %b, expected %b", name, preempt, ep);
        end
    endtask

    int owners[$];

    initial begin
        checks   = 0;
        failures = 0;
        rst = 1'b1;
        enb = 1'b0;
        req = 4'b0000;

        //                rst   enb   req      gnt      id    valid pre
        vecs.push_back('{1'b1, 1'b0, 4'b1111, 4'b0000, 2'd0, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 4'b1111, 4'b0000, 2'd0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 4'b1111, 4'b0000, 2'd0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 4'b0110, 4'b0100, 2'd2, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 4'b0110, 4'b0100, 2'd2, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 4'b0010, 4'b0000, 2'd2, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 4'b1010, 4'b0010, 2'd1, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 4'b1010, 4'b0010, 2'd1, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 4'b1000, 4'b0000, 2'd1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 4'b1000, 4'b1000, 2'd3, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 4'b1000, 4'b1000, 2'd3, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 4'b1000, 4'b1000, 2'd3, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 4'b1000, 4'b1000, 2'd3, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 4'b1000, 4'b0000, 2'd3, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 1'b1, 4'b1000, 4'b1000, 2'd3, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 4'b1000, 4'b0000, 2'd3, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 4'b1000, 4'b0000, 2'd3, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 4'b0001, 4'b0000, 2'd0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0});
`ifdef PRIO_ARBITER_RR_EN
        // Pointer sits at 2, so the search order is 1,0,3,2.
        vecs.push_back('{1'b0, 1'b1, 4'b1111, 4'b0010, 2'd1, 1'b1, 1'b0});
        owners = '{3, 2, 1, 0, 3};
`else
        vecs.push_back('{1'b0, 1'b1, 4'b1111, 4'b1000, 2'd3, 1'b1, 1'b0});
        owners = '{3, 3, 3};
`endif

        @(posedge clk);
        #1;
        foreach (vecs[i]) begin
            apply_stimulus(vecs[i].rst, vecs[i].enb, vecs[i].req);
            check_output($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].id, vecs[i].valid, vecs[i].pre);
        end

        // All four requesting continuously: each owner holds for HOLD cycles, then a preempt turnaround.
        apply_stimulus(1'b1, 1'b1, 4'b1111);
        check_output("seq_reset", 4'b0000, 2'd0, 1'b0, 1'b0);
        foreach (owners[n]) begin
            for (int c = 0; c < HOLD; c++) begin
                apply_stimulus(1'b0, 1'b1, 4'b1111);
                check_output($sformatf("seq%0d_hold%0d", n, c), 4'b0001 << owners[n],
                             2'(owners[n]), 1'b1, 1'b0);
            end
            apply_stimulus(1'b0, 1'b1, 4'b1111);
            check_output($sformatf("seq%0d_preempt", n), 4'b0000, 2'(owners[n]), 1'b0, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/prio_arbiter.md
# prio_arbiter

Sequential 4-requester arbiter that shares one downstream resource among requesters using priority encoding (index 3 highest by default). Issues a registered one-hot grant plus encoded owner ID, holds the grant while the owner keeps requesting, and forcibly releases it after a bounded hold time. Sits between requester blocks and the shared resource. It replaces a purely combinational priority encode with a grant that remains stable across cycles.

## Interface
- MAX_HOLD, 8, maximum consecutive cycles one grant may stay high; legal range 1..255.
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- enb  input  1  arbiter enable; low blocks new grants and releases any current grant.
- req  input  4  request vector; bit i belongs to requester i.
- gnt  output  4  one-hot grant, registered; all zero when no owner.
- gnt_id  output  2  encoded index of the current owner; holds the last owner's index when gnt_valid is 0.
- gnt_valid  output  1  high while any gnt bit is high.
- preempt  output  1  single-cycle pulse marking a forced release by the hold limit.

## Operation
- The FSM has two states:
  - IDLE: no owner; evaluates requests.
  - BUSY: grant is held.
- IDLE behaviour:
  - If enb=1 and req!=0: select the winner, set gnt=onehot(winner), gnt_id=winner, gnt_valid=1, hold counter=1, and go to BUSY.
  - Otherwise remain in IDLE with outputs zero (except gnt_id).
- BUSY checks, evaluated in this order each edge:
  1. enb=0 or req[gnt_id]=0: release. Clear gnt and gnt_valid, set preempt=0, go to IDLE.
  2. Hold counter == MAX_HOLD: release, pulse preempt=1 for one cycle, go to IDLE.
  3. Otherwise: increment the hold counter and keep the grant.
- A mandatory one-cycle IDLE turnaround occurs after every release. gnt is never handed directly from one owner to another.
- Requests from non-owners are ignored while in BUSY. Changes in req bits other than the owner's have no effect.
- Winner selection without round-robin: the highest set index wins (3 > 2 > 1 > 0).
- A preempted requester that still asserts req regains the grant after the turnaround if it remains the highest-priority request.
- The hold counter is 8 bits wide and never wraps. It is compared against MAX_HOLD before incrementing.
- Reset values: state=IDLE, gnt=4'b0000, gnt_id=2'b00, gnt_valid=0, preempt=0, hold counter=0, round-robin pointer=0.
- Reset asserted mid-grant clears everything at that edge, regardless of req or enb.

## Timing
- Grant latency: req asserted and sampled at edge N in IDLE produces gnt visible after edge N, i.e. one cycle.
- Release latency: owner req sampled low at edge N produces gnt low after edge N.
- Earliest re-grant: after edge N+1.
- The maximum grant width is exactly MAX_HOLD cycles. With MAX_HOLD=1, the grant is high for one cycle, and preempt pulses after it whenever the owner still requests.
- If the owner drops req on the same edge the counter reaches MAX_HOLD, the release is a normal release with preempt=0.
- preempt is high for exactly the cycle following the forced-release edge, which coincides with the turnaround IDLE cycle.
- All outputs come directly from flops; no combinational path exists from req or enb to any output.

## Configuration
- Macro: PRIO_ARBITER_RR_EN.
- Defined: rotating priority driven by a 2-bit pointer last_id, which is updated to the winner on each grant.
  - Search order is last_id-1, last_id-2, last_id-3, last_id (mod 4), first set request wins.
  - After reset, last_id=0, so the order is 3,2,1,0, identical to fixed priority.
- Undefined: fixed priority, index 3 highest. The pointer logic is absent.

## Test plan
- Reset and idle: rst=1 for 2 cycles with req=4'b1111 -> gnt=0, gnt_valid=0, preempt=0, gnt_id=0. Release rst with enb=0 -> no grant.
- Priority and latency: enb=1, req=4'b0110 -> gnt=4'b0100 and gnt_id=2 one cycle later. Owner drops req[2] -> gnt=0 next cycle, then one idle cycle, then gnt=4'b0010.
- Hold limit: MAX_HOLD=4, req=4'b1000 held high -> gnt high 4 cycles, preempt pulse 1 cycle with gnt=0, then gnt=4'b1000 again (fixed mode).
- Owner stability: owner=1 (req=4'b0010); raise req[3] mid-grant -> gnt stays 4'b0010 until release, then 4'b1000 after turnaround.
- enb and reset mid-grant: enb drops during BUSY -> gnt=0 next cycle, preempt=0. rst asserted during BUSY -> all outputs zero after that edge.
- PRIO_ARBITER_RR_EN: req=4'b1111 held and MAX_HOLD=2 -> successive owners 3,2,1,0,3 with one idle cycle between each.
